// File: rtl/sigmoid_stage.sv
// Purpose: piecewise-linear sigmoid over a frame of NEURONS z values, buffered and replayed in index order.
// Latency: 3-stage pipeline into the frame buffer; readout begins 4 cycles after the last accept of a frame.
// Backpressure: z_ready drops while the frame drains/reads out; readout beats hold stable while sig_ready is low.
module sigmoid_stage #(
    parameter int NEURONS = 40,
    parameter int ZW      = 32,
    parameter int FRAC    = 12,
    parameter int SW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [ZW-1:0] z_in,
    input  logic          z_valid,
    output logic          z_ready,
    output logic [SW-1:0] sig_out,
    output logic [5:0]    sig_index,
    output logic          sig_valid,
    input  logic          sig_ready,
    output logic          frame_done,
    output logic          busy
);

    localparam int CW = $clog2(NEURONS + 1);

    // Segment breakpoints of |z| in Q.FRAC: 1.0, 2.375 (19/8) and 5.0.
    localparam logic [ZW-2:0] X_LO  = (ZW-1)'(1)  << FRAC;
    localparam logic [ZW-2:0] X_MID = (ZW-1)'(19) << (FRAC - 3);
    localparam logic [ZW-2:0] X_HI  = (ZW-1)'(5)  << FRAC;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        READOUT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] acc_cnt;
    logic [5:0]    ptr;
    logic [5:0]    ptr_nxt;
    logic          z_fire;

    // Stage 1 registers: sign, saturated magnitude, segment, buffer slot.
    logic          s1_vld;
    logic          s1_neg;
    logic [ZW-2:0] s1_x;
    logic [1:0]    s1_seg;
    logic [5:0]    s1_idx;

    // Stage 2 registers: f in Q.12 plus carried sign and slot.
    logic          s2_vld;
    logic          s2_neg;
    logic [12:0]   s2_f12;
    logic [5:0]    s2_idx;

    logic [ZW-2:0] z_abs;
    logic [1:0]    z_seg;
    logic [ZW-2:0] x12;
    logic [12:0]   f12;
    logic [SW-1:0] s3_sig;

    logic [SW-1:0] sig_buf [NEURONS];

    assign z_ready = (state == COLLECT) && (acc_cnt < CW'(NEURONS));
    assign z_fire  = z_valid && z_ready;
    assign ptr_nxt = ptr + 6'd1;
    assign busy    = (state != COLLECT) || s1_vld || s2_vld;

    // Magnitude with the most negative input clamped, then segment selection.
    always_comb begin
        z_abs = z_in[ZW-2:0];
        if (z_in[ZW-1]) begin
            if (z_in[ZW-2:0] == '0) begin
                z_abs = '1;
            end else begin
                z_abs = ~z_in[ZW-2:0] + (ZW-1)'(1);
            end
        end
        if (z_abs >= X_HI) begin
            z_seg = 2'd3;
        end else if (z_abs >= X_MID) begin
            z_seg = 2'd2;
        end else if (z_abs >= X_LO) begin
            z_seg = 2'd1;
        end else begin
            z_seg = 2'd0;
        end
    end

    // Bring the magnitude to Q.12 so the segment offsets below are format independent.
    generate
        if (FRAC >= 12) begin : g_align_dn
            assign x12 = s1_x >> (FRAC - 12);
        end else begin : g_align_up
            assign x12 = s1_x << (12 - FRAC);
        end
    endgenerate

    // Piecewise-linear f(|z|) in Q.12; in every non-saturated segment the shifted term is small enough for 13 bits.
    always_comb begin
        f12 = 13'd4096;
        case (s1_seg)
            2'd3:    f12 = 13'd4096;
            2'd2:    f12 = 13'(x12 >> 5) + 13'd3456;
            2'd1:    f12 = 13'(x12 >> 3) + 13'd2560;
            default: f12 = 13'(x12 >> 2) + 13'd2048;
        endcase
    end

    // Map f back through the sign and down to Q0.SW, clamping 1.0 to the largest code.
    always_comb begin
        s3_sig = SW'(s2_f12 >> 2);
        if (s2_neg) begin
            s3_sig = SW'((13'd4096 - s2_f12) >> 2);
        end else if ((s2_f12 >> 2) > 13'd1023) begin
            s3_sig = {SW{1'b1}};
        end
    end

    // Pipeline valid bits; the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= z_fire;
            s2_vld <= s1_vld;
        end
    end

    // Pipeline payload; qualified by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        s1_neg <= z_in[ZW-1];
        s1_x   <= z_abs;
        s1_seg <= z_seg;
        s1_idx <= 6'(acc_cnt);
        s2_neg <= s1_neg;
        s2_f12 <= f12;
        s2_idx <= s1_idx;
    end

    // Third stage: store the result in accept order.
    always_ff @(posedge clk) begin
        if (s2_vld) begin
            sig_buf[s2_idx] <= s3_sig;
        end
    end

    // Frame control: collect, wait for the pipeline to empty, then replay the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            acc_cnt    <= '0;
            ptr        <= '0;
            sig_valid  <= 1'b0;
            sig_out    <= '0;
            sig_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (z_fire) begin
                        acc_cnt <= acc_cnt + CW'(1);
                        if (acc_cnt == CW'(NEURONS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_vld && !s2_vld) begin
                        state <= READOUT;
                        ptr   <= '0;
                    end
                end
                READOUT: begin
                    if (!sig_valid) begin
                        sig_valid <= 1'b1;
                        sig_out   <= sig_buf[ptr];
                        sig_index <= ptr;
                    end else if (sig_ready) begin
                        if (ptr == 6'(NEURONS - 1)) begin
                            state      <= COLLECT;
                            acc_cnt    <= '0;
                            ptr        <= '0;
                            sig_valid  <= 1'b0;
                            sig_out    <= '0;
                            sig_index  <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            ptr       <= ptr_nxt;
                            sig_out   <= sig_buf[ptr_nxt];
                            sig_index <= ptr_nxt;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_stage.sv
// Directed bench for sigmoid_stage: table of z values with hand-computed sigmoid codes,
// replayed as whole frames, plus sequences for stalls, held z_valid and mid-frame reset.
module tb_sigmoid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] z_in = '0;
    logic        z_valid = 1'b0;
    logic        z_ready;
    logic [9:0]  sig_out;
    logic [5:0]  sig_index;
    logic        sig_valid;
    logic        sig_ready = 1'b1;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    sigmoid_stage dut (
        .clk        (clk),
        .rst        (rst),
        .z_in       (z_in),
        .z_valid    (z_valid),
        .z_ready    (z_ready),
        .sig_out    (sig_out),
        .sig_index  (sig_index),
        .sig_valid  (sig_valid),
        .sig_ready  (sig_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] z;
        int          exp;
    } vec_t;

    vec_t vt [20];
    int   exp_frame [40];

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // sig_ready: always high in mode 0, random in mode 1.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) sig_ready = 1'($urandom_range(0, 1));
        else sig_ready = 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records transfers and checks per-cycle output rules.
    logic [31:0] acc_q [$];
    int          beat_idx [$];
    int          beat_dat [$];
    int          fd_count = 0;
    int          last_acc_cyc = 0;
    int          rise_cyc = 0;
    logic        prev_sv = 1'b0, prev_stall = 1'b0, prev_fd = 1'b0, prev_xfer_last = 1'b0;
    logic [9:0]  prev_out = '0;
    logic [5:0]  prev_idx = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sv = 1'b0;
            prev_stall = 1'b0;
            prev_fd = 1'b0;
            prev_xfer_last = 1'b0;
        end else begin
            if (z_valid && z_ready) begin
                acc_q.push_back(z_in);
                last_acc_cyc = cyc + 1;
            end
            if (sig_valid) begin
                chk("z_ready_low_in_readout", z_ready, 0);
                chk("busy_in_readout", busy, 1);
            end else begin
                chk("outputs_zero_when_idle", {sig_index, sig_out}, 0);
            end
            if (prev_stall) begin
                chk("stall_hold_valid", sig_valid, 1);
                chk("stall_hold_data", sig_out, prev_out);
                chk("stall_hold_index", sig_index, prev_idx);
            end
            if (sig_valid && !prev_sv) rise_cyc = cyc;
            if (frame_done) begin
                fd_count++;
                chk("frame_done_one_cycle", prev_fd, 0);
                chk("frame_done_after_last_beat", prev_xfer_last, 1);
            end
            if (sig_valid && sig_ready) begin
                beat_idx.push_back(int'(sig_index));
                beat_dat.push_back(int'(sig_out));
            end
            prev_xfer_last = sig_valid && sig_ready && (sig_index == 6'd39);
            prev_stall = sig_valid && !sig_ready;
            prev_out = sig_out;
            prev_idx = sig_index;
            prev_sv = sig_valid;
            prev_fd = frame_done;
        end
    end

    task automatic send_z(input logic [31:0] v);
        int n;
        n = 0;
        z_in = v;
        z_valid = 1'b1;
        @(negedge clk);
        while (!z_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("z_accept_timeout", n < 500, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_timeout", n < 3000, 1);
    endtask

    task automatic verify_frame(input int base);
        chk("beat_count", beat_idx.size() - base, 40);
        for (int k = 0; k < 40; k++) begin
            if (base + k < beat_idx.size()) begin
                chk("beat_index", beat_idx[base + k], k);
                chk("beat_data", beat_dat[base + k], exp_frame[k]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int fdb;
        int accb;

        vt[0]  = '{32'd0, 512};
        vt[1]  = '{32'd4096, 768};
        vt[2]  = '{32'(-4096), 256};
        vt[3]  = '{32'd20480, 1023};
        vt[4]  = '{32'(-20480), 0};
        vt[5]  = '{32'h8000_0000, 0};
        vt[6]  = '{32'h7FFF_FFFF, 1023};
        vt[7]  = '{32'd2048, 640};
        vt[8]  = '{32'(-2048), 384};
        vt[9]  = '{32'd9728, 940};
        vt[10] = '{32'd9727, 943};
        vt[11] = '{32'(-9728), 84};
        vt[12] = '{32'd20479, 1023};
        vt[13] = '{32'(-20479), 0};
        vt[14] = '{32'd4095, 767};
        vt[15] = '{32'(-1), 512};
        vt[16] = '{32'd6000, 827};
        vt[17] = '{32'(-6000), 196};
        vt[18] = '{32'd12000, 957};
        vt[19] = '{32'(-1000), 449};

        // Reset state
        idle(3);
        rst = 1'b0;
        chk("rst_z_ready", z_ready, 1);
        chk("rst_sig_valid", sig_valid, 0);
        chk("rst_sig_out", sig_out, 0);
        chk("rst_sig_index", sig_index, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);

        // Frame 1: back-to-back, sig_ready held high
        base = beat_idx.size();
        fdb = fd_count;
        for (int i = 0; i < 40; i++) begin
            exp_frame[i] = vt[i % 20].exp;
            send_z(vt[i % 20].z);
        end
        z_valid = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_z_ready", z_ready, 0);
        chk("drain_sig_valid", sig_valid, 0);
        wait_fd();
        idle(3);
        verify_frame(base);
        chk("readout_latency", rise_cyc - last_acc_cyc, 4);
        chk("frame1_done_count", fd_count - fdb, 1);
        chk("frame1_idle_busy", busy, 0);

        // Frame 2: random sig_ready, z_valid held through readout
        ready_mode = 1;
        base = beat_idx.size();
        accb = acc_q.size();
        for (int i = 0; i < 40; i++) begin
            exp_frame[i] = vt[(i + 7) % 20].exp;
            send_z(vt[(i + 7) % 20].z);
        end
        z_in = vt[2].z;
        z_valid = 1'b1;
        wait_fd();
        @(posedge clk);
        #1;
        ready_mode = 0;
        verify_frame(base);
        chk("held_z_accept_count", acc_q.size() - accb, 41);
        if (acc_q.size() > accb + 40) chk("held_z_first_of_next", acc_q[accb + 40], vt[2].z);

        // Frame 3: index 0 is the z held during the previous readout
        base = beat_idx.size();
        exp_frame[0] = vt[2].exp;
        for (int i = 1; i < 40; i++) begin
            exp_frame[i] = vt[i % 20].exp;
            send_z(vt[i % 20].z);
        end
        z_valid = 1'b0;
        wait_fd();
        idle(3);
        verify_frame(base);

        // Reset after 17 accepts, then a full fresh frame
        fdb = fd_count;
        for (int i = 0; i < 17; i++) send_z(vt[i].z);
        z_valid = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("midrst_z_ready", z_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sig_valid", sig_valid, 0);
        base = beat_idx.size();
        for (int i = 0; i < 40; i++) begin
            exp_frame[i] = vt[(i + 3) % 20].exp;
            send_z(vt[(i + 3) % 20].z);
        end
        z_valid = 1'b0;
        wait_fd();
        idle(10);
        verify_frame(base);
        chk("midrst_done_count", fd_count - fdb, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sigmoid_stage.md
SIGMOID_STAGE -- requirements
Module: sigmoid_stage

Interface
REQ-001 Parameter NEURONS, default 40: number of z values per frame.
REQ-002 Parameter ZW, default 32: width of the signed z input.
REQ-003 Parameter FRAC, default 12: fractional bits of z (two's complement, Q(ZW-FRAC).FRAC).
REQ-004 Parameter SW, default 10: sigmoid output width, unsigned Q0.SW.
REQ-005 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port z_in, input, ZW: pre-activation accumulator value from the MAC stage.
REQ-008 Port z_valid, input, 1: z_in is valid this cycle.
REQ-009 Port z_ready, output, 1: the block accepts z_in this cycle.
REQ-010 Port sig_out, output, SW: sigmoid value for the downstream backprop stage.
REQ-011 Port sig_index, output, 6: neuron index of sig_out, 0..NEURONS-1.
REQ-012 Port sig_valid, output, 1: sig_out and sig_index are valid.
REQ-013 Port sig_ready, input, 1: downstream accepts sig_out this cycle.
REQ-014 Port frame_done, output, 1: one-cycle pulse after the last readout beat of a frame.
REQ-015 Port busy, output, 1: high whenever the state is not COLLECT or the pipeline holds data.

Function
REQ-016 A z transfer occurs on a cycle with z_valid=1 and z_ready=1; a sig transfer occurs on a cycle with sig_valid=1 and sig_ready=1.
REQ-017 z_ready = (state==COLLECT) and (accept count < NEURONS); it is combinational from registered state only.
REQ-018 Each accepted z passes through a 3-stage pipeline: S1 registers sign, |z| (saturated to 2^(ZW-1)-1 for the most negative input) and segment; S2 registers f12; S3 writes the result to buffer[accept order].
REQ-019 Latency is exactly 3 cycles from the accept edge to the buffer write; the pipeline never stalls, and one z may be accepted every cycle.
REQ-020 With x = |z| in Q.FRAC and f12 in Q.12, truncate every shift: x >= 5.0 -> f12 = 4096; 2.375 <= x < 5.0 -> (x>>5) + 3456; 1.0 <= x < 2.375 -> (x>>3) + 2560; x < 1.0 -> (x>>2) + 2048.
REQ-021 For z >= 0, sig = min(f12>>2, 1023); for z < 0, sig = (4096 - f12)>>2; the result is SW bits and never wraps.
REQ-022 State COLLECT: accept z until NEURONS values have been accepted, then go to DRAIN.
REQ-023 State DRAIN: wait until the NEURONS-th buffer write completes, then go to READOUT with the read pointer at 0.
REQ-024 State READOUT: sig_valid=1, sig_out=buffer[ptr], sig_index=ptr; each sig transfer increments ptr.
REQ-025 In READOUT, sig_out and sig_index hold stable while sig_valid=1 and sig_ready=0.
REQ-026 On the transfer with ptr=NEURONS-1: go to COLLECT, clear the counters, and pulse frame_done on the next cycle; z_ready may rise on that same next cycle.
REQ-027 z_ready=0 throughout DRAIN and READOUT; z_valid is ignored there and accepts no data.
REQ-028 sig_valid=0 in COLLECT and DRAIN.
REQ-029 sig_out and sig_index are 0 whenever sig_valid=0.

Reset
REQ-030 While rst=1 at a clock edge: state=COLLECT, counters and ptr=0, pipeline valid bits=0, sig_valid=0, sig_out=0, sig_index=0, frame_done=0, busy=0, and z_ready=1 on the following cycle.
REQ-031 Buffer contents are not reset.
REQ-032 Reset asserted mid-frame or mid-readout discards all partial data; no frame_done is produced for the aborted frame.

Verification
REQ-033 z = 0, 4096, -4096, 20480, -20480 -> sig_out = 512, 768, 256, 1023, 0 at indices 0..4 of the frame.
REQ-034 z = 0x80000000 and z = 0x7FFFFFFF -> 0 and 1023; no overflow or wrap.
REQ-035 Send 40 back-to-back values with sig_ready=1 -> readout starts 4 cycles after the 40th accept, produces 40 beats with indices 0..39, then frame_done pulses for exactly 1 cycle.
REQ-036 Toggle sig_ready randomly during readout -> no beat is lost or duplicated, and data stays stable while stalled.
REQ-037 Hold z_valid=1 during READOUT -> no z is accepted; the next frame's index 0 equals the first z presented after frame_done.
REQ-038 Assert rst after 17 accepts, then send a full frame -> exactly 40 fresh beats and one frame_done.
